// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS multicycle control unit.
// Holds the state encoding, opcode/funct values, datapath mux encodings and the
// DECODE dispatch helper.
// Build option: MIPS_CTRL_ORI_EN adds ori decode (ORIEX state); undefined makes ori illegal.
package mips_ctrl_pkg;

  // FSM state encoding, also exposed on the debug state port
  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StMemAdr = 4'd2;
  localparam logic [3:0] StMemRd  = 4'd3;
  localparam logic [3:0] StMemWb  = 4'd4;
  localparam logic [3:0] StMemWr  = 4'd5;
  localparam logic [3:0] StExec   = 4'd6;
  localparam logic [3:0] StAluWb  = 4'd7;
  localparam logic [3:0] StBranch = 4'd8;
  localparam logic [3:0] StAddiEx = 4'd9;
  localparam logic [3:0] StIwb    = 4'd10;
  localparam logic [3:0] StJump   = 4'd11;
  localparam logic [3:0] StOriEx  = 4'd12;

  // Opcodes, instruction[31:26]
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type funct, instruction[5:0]
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // alu_op
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;
  localparam logic [1:0] AluOpOr    = 2'b11;

  // alu_control
  localparam logic [2:0] AluCtlAnd = 3'b000;
  localparam logic [2:0] AluCtlOr  = 3'b001;
  localparam logic [2:0] AluCtlAdd = 3'b010;
  localparam logic [2:0] AluCtlSub = 3'b110;
  localparam logic [2:0] AluCtlSlt = 3'b111;

  // alu_src_b
  localparam logic [1:0] SrcBRd2    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmX4  = 2'b11;

  // pc_source
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // reg_dest / mem_to_reg
  localparam logic [1:0] RegDstRt    = 2'b00;
  localparam logic [1:0] RegDstRd    = 2'b01;
  localparam logic [1:0] MemToRegAlu = 2'b00;
  localparam logic [1:0] MemToRegMem = 2'b01;

  // State entered after DECODE; StFetch means the opcode is unsupported.
  function automatic logic [3:0] dispatch_state(input logic [5:0] opcode);
    logic [3:0] nxt;
    case (opcode)
      OpLw, OpSw: nxt = StMemAdr;
      OpRtype:    nxt = StExec;
      OpBeq:      nxt = StBranch;
      OpAddi:     nxt = StAddiEx;
      OpJ:        nxt = StJump;
`ifdef MIPS_CTRL_ORI_EN
      OpOri:      nxt = StOriEx;
`endif
      default:    nxt = StFetch;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU function decoder: maps (alu_op, funct) to the 3-bit ALU control code.
// Ports: alu_op (2) and funct (6) in; alu_control (3) out. Purely combinational.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = AluCtlAdd;
    unique case (alu_op)
      AluOpAdd: alu_control = AluCtlAdd;
      AluOpSub: alu_control = AluCtlSub;
      AluOpOr:  alu_control = AluCtlOr;
      AluOpFunct: begin
        case (funct)
          FnAdd:   alu_control = AluCtlAdd;
          FnSub:   alu_control = AluCtlSub;
          FnAnd:   alu_control = AluCtlAnd;
          FnOr:    alu_control = AluCtlOr;
          FnSlt:   alu_control = AluCtlSlt;
          default: alu_control = AluCtlAdd;
        endcase
      end
      default: alu_control = AluCtlAdd;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// over a shared datapath, stalling on mem_ready in FETCH, MEMRD and MEMWR.
// Ports: clk, reset (sync, active-high), opcode/funct from the IR, zero flag, mem_ready;
// outputs are every datapath mux select and write enable, alu_control, a registered
// illegal_op pulse and the current state for debug.
// Build option: MIPS_CTRL_ORI_EN enables ori (ORIEX state, ori_ctrl); otherwise ori is illegal.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write_en,
  output logic       reg_write_en,
  output logic [1:0] reg_dest,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] alu_control,
  output logic       ori_ctrl,
  output logic [1:0] pc_source,
  output logic       branch,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] state_q, state_d;
  logic [3:0] out_state;
  logic       illegal_q, illegal_d;
  logic       ir_write_raw, pc_en_raw, mem_write_raw, reg_write_raw, branch_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_d = (state_q == StDecode) && (dispatch_state(opcode) == StFetch);

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: state_d = dispatch_state(opcode);
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
      StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StIwb;
`ifdef MIPS_CTRL_ORI_EN
      StOriEx:  state_d = StIwb;
`endif
      default:  state_d = StFetch;
    endcase
  end

  // During reset the mux selects follow FETCH so the datapath sees a quiet PC+4 path.
  assign out_state = reset ? StFetch : state_q;

  always_comb begin
    iord          = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    reg_dest      = RegDstRt;
    mem_to_reg    = MemToRegAlu;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBRd2;
    alu_op        = AluOpAdd;
    ori_ctrl      = 1'b0;
    pc_source     = PcSrcAlu;
    branch_raw    = 1'b0;
    pc_en_raw     = 1'b0;
    case (out_state)
      StFetch: begin
        alu_src_b    = SrcBFour;
        ir_write_raw = mem_ready;
        pc_en_raw    = mem_ready;
      end
      StDecode: alu_src_b = SrcBImmX4;  // branch target precomputed here
      StMemAdr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        mem_to_reg    = MemToRegMem;
        reg_write_raw = 1'b1;
      end
      StMemWr: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = AluOpFunct;
      end
      StAluWb: begin
        reg_dest      = RegDstRd;
        reg_write_raw = 1'b1;
      end
      StBranch: begin
        alu_src_a  = 1'b1;
        alu_op     = AluOpSub;
        pc_source  = PcSrcAluOut;
        branch_raw = 1'b1;
        pc_en_raw  = zero;
      end
`ifdef MIPS_CTRL_ORI_EN
      StOriEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        alu_op    = AluOpOr;
        ori_ctrl  = 1'b1;
      end
`endif
      StIwb: reg_write_raw = 1'b1;
      StJump: begin
        pc_source = PcSrcJump;
        pc_en_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset suppresses every strobe of the cycle it is asserted in.
  assign ir_write     = ir_write_raw & ~reset;
  assign pc_en        = pc_en_raw & ~reset;
  assign mem_write_en = mem_write_raw & ~reset;
  assign reg_write_en = reg_write_raw & ~reset;
  assign branch       = branch_raw & ~reset;
  assign illegal_op   = illegal_q & ~reset;
  assign state        = state_q;

  mips_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: table-driven per-instruction vectors,
// hand-written stall/reset sequences and a randomized run against an instruction-plan model.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b1;
  logic       iord, ir_write, mem_write_en, reg_write_en, alu_src_a, ori_ctrl, branch, pc_en;
  logic       illegal_op;
  logic [1:0] reg_dest, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic [2:0] alu_control;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .ir_write(ir_write), .mem_write_en(mem_write_en),
    .reg_write_en(reg_write_en), .reg_dest(reg_dest), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .alu_control(alu_control), .ori_ctrl(ori_ctrl), .pc_source(pc_source), .branch(branch),
    .pc_en(pc_en), .illegal_op(illegal_op), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       iord, ir_write, mem_write_en, reg_write_en;
    logic [1:0] reg_dest, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic [2:0] alu_control;
    logic       ori_ctrl;
    logic [1:0] pc_source;
    logic       branch, pc_en, illegal_op;
  } outs_t;

  outs_t got;
  assign got = {state, iord, ir_write, mem_write_en, reg_write_en, reg_dest, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, alu_control, ori_ctrl, pc_source, branch, pc_en,
                illegal_op};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, let outputs settle, caller samples.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic mr, input logic rst);
    @(negedge clk);
    opcode = op; funct = fn; zero = z; mem_ready = mr; reset = rst;
    #1;
  endtask

  // Leaves reset asserted; the next step() releases it with the DUT sitting in FETCH.
  task automatic do_reset();
    step(6'h3f, 6'h0, 1'b0, 1'b1, 1'b1);
    step(6'h3f, 6'h0, 1'b0, 1'b1, 1'b1);
    check("reset_state", 32'(state), 32'd0);
    check("reset_strobes", 32'({ir_write, pc_en, mem_write_en, reg_write_en, branch,
                                illegal_op}), 32'd0);
    check("reset_selects", 32'({iord, alu_src_a, alu_src_b, alu_op, pc_source}),
          32'({1'b0, 1'b0, 2'b01, 2'b00, 2'b00}));
  endtask

  // ---------------- reference model: instruction plans ----------------
  typedef enum int {
    PFetch = 0, PDecode = 1, PMemAdr = 2, PMemRd = 3, PMemWb = 4, PMemWr = 5, PExec = 6,
    PAluWb = 7, PBranch = 8, PAddiEx = 9, PIwb = 10, PJump = 11, POriEx = 12
  } ph_t;
  typedef ph_t ph_q_t[$];

  function automatic logic ori_supported();
`ifdef MIPS_CTRL_ORI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic ph_q_t plan(input logic [5:0] op);
    ph_q_t q;
    q = '{PFetch, PDecode};
    if (op == 6'b100011) q = '{PFetch, PDecode, PMemAdr, PMemRd, PMemWb};
    else if (op == 6'b101011) q = '{PFetch, PDecode, PMemAdr, PMemWr};
    else if (op == 6'b000000) q = '{PFetch, PDecode, PExec, PAluWb};
    else if (op == 6'b000100) q = '{PFetch, PDecode, PBranch};
    else if (op == 6'b001000) q = '{PFetch, PDecode, PAddiEx, PIwb};
    else if (op == 6'b000010) q = '{PFetch, PDecode, PJump};
    else if (op == 6'b001101 && ori_supported()) q = '{PFetch, PDecode, POriEx, PIwb};
    return q;
  endfunction

  function automatic logic [2:0] r_type_code(input logic [5:0] fn);
    logic [5:0] fns  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] code [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    for (int i = 0; i < 5; i++) if (fns[i] == fn) return code[i];
    return 3'b010;
  endfunction

  function automatic outs_t expect_for(input ph_t ph, input logic mr, input logic z,
                                       input logic [5:0] fn, input logic ill);
    outs_t e = '0;
    e.st = 4'(ph);
    e.illegal_op = ill;
    e.alu_control = 3'b010;
    case (ph)
      PFetch:  begin e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
      PDecode: e.alu_src_b = 2'b11;
      PMemAdr, PAddiEx: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      PMemRd:  e.iord = 1'b1;
      PMemWb:  begin e.mem_to_reg = 2'b01; e.reg_write_en = 1'b1; end
      PMemWr:  begin e.iord = 1'b1; e.mem_write_en = 1'b1; end
      PExec:   begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; e.alu_control = r_type_code(fn); end
      PAluWb:  begin e.reg_dest = 2'b01; e.reg_write_en = 1'b1; end
      PBranch: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.alu_control = 3'b110;
        e.pc_source = 2'b01; e.branch = 1'b1; e.pc_en = z;
      end
      POriEx:  begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b11;
        e.alu_control = 3'b001; e.ori_ctrl = 1'b1;
      end
      PIwb:    e.reg_write_en = 1'b1;
      PJump:   begin e.pc_source = 2'b10; e.pc_en = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // ---------------- table vectors ----------------
  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         len;      // cycles from FETCH back to FETCH
    logic [2:0] ctl2;     // alu_control in the third cycle
    logic       pc_en2;   // pc_en in the third cycle
    int         ill;      // illegal_op pulses seen
  } vec_t;

  vec_t vecs[$];

  initial begin : main
    int k, ill_cnt;
    logic [2:0] ctl2;
    logic pc2;
    ph_q_t q;
    logic ill_flag, instr_illegal;
    logic [5:0] op, fn;
    logic [5:0] ops [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                            6'b000010, 6'b001101};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    outs_t e;
    int guard;

    vecs.push_back('{"lw",      6'b100011, 6'h00, 1'b0, 5, 3'b010, 1'b0, 0});
    vecs.push_back('{"sw",      6'b101011, 6'h00, 1'b0, 4, 3'b010, 1'b0, 0});
    vecs.push_back('{"r_add",   6'b000000, 6'b100000, 1'b0, 4, 3'b010, 1'b0, 0});
    vecs.push_back('{"r_sub",   6'b000000, 6'b100010, 1'b0, 4, 3'b110, 1'b0, 0});
    vecs.push_back('{"r_and",   6'b000000, 6'b100100, 1'b0, 4, 3'b000, 1'b0, 0});
    vecs.push_back('{"r_or",    6'b000000, 6'b100101, 1'b0, 4, 3'b001, 1'b0, 0});
    vecs.push_back('{"r_slt",   6'b000000, 6'b101010, 1'b0, 4, 3'b111, 1'b0, 0});
    vecs.push_back('{"r_unk",   6'b000000, 6'b111111, 1'b0, 4, 3'b010, 1'b0, 0});
    vecs.push_back('{"beq_t",   6'b000100, 6'h00, 1'b1, 3, 3'b110, 1'b1, 0});
    vecs.push_back('{"beq_nt",  6'b000100, 6'h00, 1'b0, 3, 3'b110, 1'b0, 0});
    vecs.push_back('{"addi",    6'b001000, 6'h00, 1'b0, 4, 3'b010, 1'b0, 0});
    vecs.push_back('{"j",       6'b000010, 6'h00, 1'b0, 3, 3'b010, 1'b1, 0});
`ifdef MIPS_CTRL_ORI_EN
    vecs.push_back('{"ori",     6'b001101, 6'h00, 1'b0, 4, 3'b001, 1'b0, 0});
`else
    vecs.push_back('{"ori",     6'b001101, 6'h00, 1'b0, 2, 3'b010, 1'b1, 1});
`endif
    vecs.push_back('{"illegal", 6'b111111, 6'h00, 1'b0, 2, 3'b010, 1'b1, 1});

    foreach (vecs[i]) begin
      do_reset();
      ill_cnt = 0; ctl2 = 'x; pc2 = 'x;
      for (k = 0; k < 20; k++) begin
        step(vecs[i].op, vecs[i].fn, vecs[i].z, 1'b1, 1'b0);
        if (k == 2) begin ctl2 = alu_control; pc2 = pc_en; end
        ill_cnt += int'(illegal_op);
        if (k > 0 && state == 4'd0) break;
      end
      check({vecs[i].name, "_latency"}, 32'(k), 32'(vecs[i].len));
      check({vecs[i].name, "_alu_control"}, 32'(ctl2), 32'(vecs[i].ctl2));
      check({vecs[i].name, "_pc_en"}, 32'(pc2), 32'(vecs[i].pc_en2));
      check({vecs[i].name, "_illegal"}, 32'(ill_cnt), 32'(vecs[i].ill));
    end

    // FETCH stalls on mem_ready
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step(6'b100011, 6'h0, 1'b0, 1'b0, 1'b0);
      check("stall_state", 32'(state), 32'd0);
      check("stall_strobes", 32'({ir_write, pc_en}), 32'd0);
    end
    step(6'b100011, 6'h0, 1'b0, 1'b1, 1'b0);
    check("stall_release", 32'({state, ir_write, pc_en}), 32'({4'd0, 1'b1, 1'b1}));
    step(6'b100011, 6'h0, 1'b0, 1'b1, 1'b0);
    check("stall_decode", 32'(state), 32'd1);

    // sw stalled in MEMWR, aborted by reset
    do_reset();
    step(6'b101011, 6'h0, 1'b0, 1'b1, 1'b0);
    step(6'b101011, 6'h0, 1'b0, 1'b1, 1'b0);
    step(6'b101011, 6'h0, 1'b0, 1'b1, 1'b0);
    check("sw_memadr", 32'(state), 32'd2);
    step(6'b101011, 6'h0, 1'b0, 1'b0, 1'b0);
    check("sw_memwr", 32'({state, mem_write_en, iord}), 32'({4'd5, 1'b1, 1'b1}));
    step(6'b101011, 6'h0, 1'b0, 1'b0, 1'b0);
    check("sw_memwr_hold", 32'({state, mem_write_en}), 32'({4'd5, 1'b1}));
    step(6'b101011, 6'h0, 1'b0, 1'b0, 1'b1);
    check("sw_reset_we", 32'({mem_write_en, iord}), 32'd0);
    step(6'b101011, 6'h0, 1'b0, 1'b0, 1'b0);
    check("sw_reset_state", 32'(state), 32'd0);

    // Randomized instruction stream against the plan model
    do_reset();
    ill_flag = 1'b0;
    for (int n = 0; n < 250; n++) begin
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      q = plan(op);
      instr_illegal = (q.size() == 2);
      guard = 0;
      while (q.size() > 0 && guard < 200) begin
        guard++;
        step(op, fn, 1'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
        e = expect_for(q[0], mem_ready, zero, fn, ill_flag);
        check("random_cycle", 32'(got), 32'(e));
        ill_flag = (q[0] == PDecode) && instr_illegal;
        if (!((q[0] == PFetch || q[0] == PMemRd || q[0] == PMemWr) && !mem_ready))
          void'(q.pop_front());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
